cop_ctrl: RTL and testbench

Parametrised coprocessor-0 for the MIPS core: CP0 register file (Count, Compare, Status, Cause, EPC, ErrorEPC, BadVAddr) plus exception/interrupt sequencing. Sits beside the execute stage; takes mtc0/mfc0, ei/di, eret, syscall/break and pipeline exceptions, samples hardware interrupt lines, and issues a one-cycle PC redirect to the fetch stage. It replaces the combinational CP0 with clocked state, a timer and prioritised exception entry.

---
 rtl/cop_defs.sv | 49 ++++
 rtl/cop_timer.sv | 59 +++++
 rtl/cop_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cop_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cop_defs.sv
// Shared CP0 definitions: operation encodings, register numbers, exception
// codes, Status/Cause bit positions and mtc0 write masks.
package cop_defs;

  typedef enum logic [2:0] {
    COP_OP_NONE = 3'd0,
    COP_OP_MV   = 3'd1,
    COP_OP_EN   = 3'd2,
    COP_OP_DIS  = 3'd3,
    COP_OP_RET  = 3'd4,
    COP_OP_SYS  = 3'd5,
    COP_OP_BRK  = 3'd6
  } cop_op_e;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;
  localparam logic [4:0] CP0_ERROREPC = 5'd30;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;

  localparam int unsigned ST_IE  = 0;
  localparam int unsigned ST_EXL = 1;
  localparam int unsigned ST_ERL = 2;
  localparam int unsigned ST_BEV = 22;

  localparam int unsigned CA_BD      = 31;
  localparam int unsigned CA_TI      = 30;
  localparam int unsigned CA_EXC_LSB = 2;

  localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF17;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

  // Merge write data into an existing register under a bit mask.
  function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                               input logic [31:0] data,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/cop_timer.sv
// CP0 timer: prescaler, Count and Compare registers, and the match pulse
// that sets Cause.TI. Writes are pre-qualified by the controller.
module cop_timer #(
  parameter int unsigned COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        count_wr,
  input  logic        compare_wr,
  input  logic [31:0] wr_data,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti_set
);

  localparam int unsigned    PW        = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(COUNT_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   count_q, count_d;
  logic [31:0]   compare_q, compare_d;
  logic          tick;

  // Next-state: prescaler wrap drives Count; a Count write beats the increment.
  // Match is judged on the incremented value, and a Compare write in the same
  // cycle suppresses it.
  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    count_d   = count_q;
    compare_d = compare_q;
    if (count_wr) begin
      count_d = wr_data;
    end else if (tick) begin
      count_d = count_q + 32'd1;
    end
    if (compare_wr) begin
      compare_d = wr_data;
    end
    ti_set = tick & ~count_wr & ~compare_wr & ((count_q + 32'd1) == compare_q);
  end

  // Timer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      count_q   <= '0;
      compare_q <= '0;
    end else begin
      presc_q   <= presc_d;
      count_q   <= count_d;
      compare_q <= compare_d;
    end
  end

  assign count   = count_q;
  assign compare = compare_q;

endmodule

// File: rtl/cop_ctrl.sv
// Coprocessor-0: CP0 register file, timer, interrupt detection and
// prioritised exception entry / return with a registered PC redirect.
module cop_ctrl
  import cop_defs::*;
#(
  parameter int unsigned NUM_HW_INT = 6,
  parameter logic [31:0] EXC_ENTRY  = 32'h8000_0180,
  parameter logic [31:0] BEV_ENTRY  = 32'hBFC0_0380,
  parameter int unsigned COUNT_DIV  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            cop_op,
  input  logic [4:0]            reg_num,
  input  logic [2:0]            reg_sel,
  input  logic                  reg_wr,
  input  logic [31:0]           in_data,
  output logic [31:0]           out_data,
  input  logic [31:0]           cur_pc,
  input  logic                  in_delay_slot,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  int_window,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic                  int_pending,
  output logic                  redirect_valid,
  output logic [31:0]           redirect_pc
);

  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] errorepc_q, errorepc_d;
  logic [31:0] badvaddr_q, badvaddr_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] count, compare;
  logic        ti_set;

  logic        sel_ok;
  logic        take_exc, take_sys, take_ret, take_int, take_entry, low_ok;
  logic        mtc0_en, count_wr, compare_wr;
  logic [4:0]  entry_code;
  logic [31:0] vector, epc_target;
  logic        ti_next;
  logic [5:0]  ip_hw;

  cop_timer #(
    .COUNT_DIV (COUNT_DIV)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_wr   (count_wr),
    .compare_wr (compare_wr),
    .wr_data    (in_data),
    .count      (count),
    .compare    (compare),
    .ti_set     (ti_set)
  );

  // Interrupt request from current state only.
  always_comb begin
    int_pending = status_q[ST_IE] & ~status_q[ST_EXL] & ~status_q[ST_ERL] &
                  (|(cause_q[15:8] & status_q[15:8]));
  end

  // Event arbitration: pipeline exception > syscall/break > eret > interrupt
  // > register writes and ei/di. Lower-priority writes are dropped.
  always_comb begin
    sel_ok     = (reg_sel == '0);
    take_exc   = exc_valid;
    take_sys   = ~exc_valid & ((cop_op == COP_OP_SYS) | (cop_op == COP_OP_BRK));
    take_ret   = ~exc_valid & ~take_sys & (cop_op == COP_OP_RET);
    take_int   = ~exc_valid & ~take_sys & ~take_ret & int_pending & int_window;
    take_entry = take_exc | take_sys | take_int;
    low_ok     = ~(take_entry | take_ret);
    mtc0_en    = low_ok & (cop_op == COP_OP_MV) & reg_wr & sel_ok;
    count_wr   = mtc0_en & (reg_num == CP0_COUNT);
    compare_wr = mtc0_en & (reg_num == CP0_COMPARE);
    if (take_exc) begin
      entry_code = exc_code;
    end else if (take_sys) begin
      entry_code = (cop_op == COP_OP_BRK) ? EXC_BP : EXC_SYS;
    end else begin
      entry_code = EXC_INT;
    end
    vector     = status_q[ST_BEV] ? BEV_ENTRY : EXC_ENTRY;
    epc_target = in_delay_slot ? (cur_pc - 32'd4) : cur_pc;
  end

  // mfc0 read mux; ei/di return the pre-update Status.
  always_comb begin
    out_data = '0;
    if ((cop_op == COP_OP_MV) && !reg_wr && sel_ok) begin
      case (reg_num)
        CP0_BADVADDR: out_data = badvaddr_q;
        CP0_COUNT:    out_data = count;
        CP0_COMPARE:  out_data = compare;
        CP0_STATUS:   out_data = status_q;
        CP0_CAUSE:    out_data = cause_q;
        CP0_EPC:      out_data = epc_q;
        CP0_ERROREPC: out_data = errorepc_q;
        default:      out_data = '0;
      endcase
    end else if ((cop_op == COP_OP_EN) || (cop_op == COP_OP_DIS)) begin
      out_data = status_q;
    end
  end

  // Register next-state for the winning event, then the per-cycle Cause
  // updates (TI sticky bit, hardware IP sampling) layered on top.
  always_comb begin
    status_d         = status_q;
    cause_d          = cause_q;
    epc_d            = epc_q;
    errorepc_d       = errorepc_q;
    badvaddr_d       = badvaddr_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (take_entry) begin
      cause_d[CA_EXC_LSB +: 5] = entry_code;
      if (!status_q[ST_EXL]) begin
        epc_d          = epc_target;
        cause_d[CA_BD] = in_delay_slot;
      end
      status_d[ST_EXL] = 1'b1;
      if ((entry_code == EXC_ADEL) || (entry_code == EXC_ADES)) begin
        badvaddr_d = exc_badvaddr;
      end
      redirect_valid_d = 1'b1;
      redirect_pc_d    = vector;
    end else if (take_ret) begin
      redirect_valid_d = 1'b1;
      if (status_q[ST_ERL]) begin
        redirect_pc_d    = errorepc_q;
        status_d[ST_ERL] = 1'b0;
      end else begin
        redirect_pc_d    = epc_q;
        status_d[ST_EXL] = 1'b0;
      end
    end else if (mtc0_en) begin
      case (reg_num)
        CP0_STATUS:   status_d   = masked_write(status_q, in_data, STATUS_WMASK);
        CP0_CAUSE:    cause_d    = masked_write(cause_q, in_data, CAUSE_WMASK);
        CP0_EPC:      epc_d      = in_data;
        CP0_ERROREPC: errorepc_d = in_data;
        default:      ;
      endcase
    end else if (low_ok && (cop_op == COP_OP_EN)) begin
      status_d[ST_IE] = 1'b1;
    end else if (low_ok && (cop_op == COP_OP_DIS)) begin
      status_d[ST_IE] = 1'b0;
    end

    // IP7 is shared between the timer and the highest hardware line.
    ti_next = cause_q[CA_TI];
    if (compare_wr) begin
      ti_next = 1'b0;
    end else if (ti_set) begin
      ti_next = 1'b1;
    end
    ip_hw          = 6'(hw_int);
    cause_d[CA_TI] = ti_next;
    cause_d[15:10] = ip_hw | {ti_next, 5'b0};
  end

  // CP0 state and redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q         <= STATUS_RESET;
      cause_q          <= '0;
      epc_q            <= '0;
      errorepc_q       <= '0;
      badvaddr_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      status_q         <= status_d;
      cause_q          <= cause_d;
      epc_q            <= epc_d;
      errorepc_q       <= errorepc_d;
      badvaddr_q       <= badvaddr_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_cop_ctrl.sv
// Self-checking bench for cop_ctrl: directed scenarios plus randomized
// register traffic and exception/return sequences against a behavioural model.
module tb_cop_ctrl;
  import cop_defs::*;

  localparam int unsigned DIV   = 2;
  localparam logic [31:0] V_EXC = 32'h8000_0180;
  localparam logic [31:0] V_BEV = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  cop_op;
  logic [4:0]  reg_num;
  logic [2:0]  reg_sel;
  logic        reg_wr;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic [31:0] cur_pc;
  logic        in_delay_slot;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        int_window;
  logic [5:0]  hw_int = '0;
  logic        int_pending;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned edges;

  cop_ctrl #(
    .NUM_HW_INT (6),
    .EXC_ENTRY  (V_EXC),
    .BEV_ENTRY  (V_BEV),
    .COUNT_DIV  (DIV)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cop_op         (cop_op),
    .reg_num        (reg_num),
    .reg_sel        (reg_sel),
    .reg_wr         (reg_wr),
    .in_data        (in_data),
    .out_data       (out_data),
    .cur_pc         (cur_pc),
    .in_delay_slot  (in_delay_slot),
    .exc_valid      (exc_valid),
    .exc_code       (exc_code),
    .exc_badvaddr   (exc_badvaddr),
    .int_window     (int_window),
    .hw_int         (hw_int),
    .int_pending    (int_pending),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #20 clk = ~clk;

  // Rising edges seen since reset release; the timer model counts ticks from it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic idle();
    cop_op = COP_OP_NONE; reg_num = '0; reg_sel = '0; reg_wr = 1'b0; in_data = '0;
    cur_pc = '0; in_delay_slot = 1'b0; exc_valid = 1'b0; exc_code = '0;
    exc_badvaddr = '0; int_window = 1'b0;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] num, input logic [2:0] sel, output logic [31:0] v);
    cop_op = COP_OP_MV; reg_num = num; reg_sel = sel; reg_wr = 1'b0;
    #1;
    v = out_data;
    idle();
  endtask

  task automatic wr(input logic [4:0] num, input logic [2:0] sel, input logic [31:0] d);
    cop_op = COP_OP_MV; reg_num = num; reg_sel = sel; reg_wr = 1'b1; in_data = d;
    cycle();
    idle();
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] pc, input logic ds);
    cop_op = o; cur_pc = pc; in_delay_slot = ds;
    cycle();
    idle();
  endtask

  task automatic reset_dut();
    idle();
    hw_int = '0;
    rst_n = 1'b0;
    #5;
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic [4:0]  zero_regs [6];
    zero_regs = '{CP0_COMPARE, CP0_CAUSE, CP0_EPC, CP0_ERROREPC, CP0_BADVADDR, 5'd7};
    idle();
    rst_n = 1'b0;
    #5;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) cycle();
    rd(CP0_COUNT, 3'd0, v);
    n_cmp++; if (v !== 32'(edges / DIV) || v !== 32'd5) begin n_err++; $display("FAIL reset_count: got %h expected %h", v, 32'd5); end
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0000) begin n_err++; $display("FAIL reset_status: got %h expected %h", v, 32'h0040_0000); end
    foreach (zero_regs[i]) begin
      rd(zero_regs[i], 3'd0, v);
      n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_reg%0d: got %h expected 0", zero_regs[i], v); end
    end
    #1;
    n_cmp++; if (out_data !== 32'd0) begin n_err++; $display("FAIL idle_out_data: got %h expected 0", out_data); end
    n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0 || int_pending !== 1'b0) begin
      n_err++; $display("FAIL reset_outputs: got rv=%b pc=%h ip=%b expected 0/0/0", redirect_valid, redirect_pc, int_pending);
    end
  endtask

  task automatic test_regs_random();
    logic [31:0] m_status, m_cause, m_epc, m_errorepc, m_compare, m_count, v, d, exp;
    int unsigned m_count_edge;
    logic [4:0]  num;
    logic [2:0]  sel;
    logic [4:0]  pick [8];
    reset_dut();
    m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_errorepc = 0; m_compare = 0;
    m_count = 0; m_count_edge = 0;
    for (int i = 0; i < 48; i++) begin
      pick = '{CP0_BADVADDR, CP0_COUNT, CP0_COMPARE, CP0_STATUS, CP0_CAUSE, CP0_EPC, CP0_ERROREPC, 5'($urandom)};
      num = pick[$urandom_range(0, 7)];
      sel = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      d   = $urandom;
      wr(num, sel, d);
      if (sel == 3'd0) begin
        if (num == CP0_STATUS)   m_status  = (m_status & ~32'h0040_FF17) | (d & 32'h0040_FF17);
        if (num == CP0_CAUSE)    m_cause   = d & 32'h0000_0300;
        if (num == CP0_EPC)      m_epc     = d;
        if (num == CP0_ERROREPC) m_errorepc = d;
        if (num == CP0_COMPARE)  m_compare = d;
        if (num == CP0_COUNT) begin m_count = d; m_count_edge = edges; end
      end
      case (num)
        CP0_STATUS:   exp = m_status;
        CP0_CAUSE:    exp = m_cause;
        CP0_EPC:      exp = m_epc;
        CP0_ERROREPC: exp = m_errorepc;
        CP0_COMPARE:  exp = m_compare;
        CP0_COUNT:    exp = m_count + 32'(edges / DIV - m_count_edge / DIV);
        default:      exp = 32'd0;
      endcase
      rd(num, 3'd0, v);
      n_cmp++; if (v !== exp) begin n_err++; $display("FAIL rand_rw reg%0d sel%0d: got %h expected %h", num, sel, v, exp); end
    end
    rd(CP0_STATUS, 3'd1, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL read_sel1: got %h expected 0", v); end
    cop_op = COP_OP_EN; #1; v = out_data; cycle(); idle();
    n_cmp++; if (v !== m_status) begin n_err++; $display("FAIL ei_old_status: got %h expected %h", v, m_status); end
    m_status[0] = 1'b1;
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v !== m_status) begin n_err++; $display("FAIL ei_status: got %h expected %h", v, m_status); end
    cop_op = COP_OP_DIS; #1; v = out_data; cycle(); idle();
    n_cmp++; if (v !== m_status) begin n_err++; $display("FAIL di_old_status: got %h expected %h", v, m_status); end
    m_status[0] = 1'b0;
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v !== m_status) begin n_err++; $display("FAIL di_status: got %h expected %h", v, m_status); end
  endtask

  task automatic test_timer();
    logic [31:0] v;
    int unsigned w, n_exp, n_seen;
    reset_dut();
    wr(CP0_COMPARE, 3'd0, 32'd20);
    wr(CP0_COUNT, 3'd0, 32'd15);
    w = edges;
    wr(CP0_STATUS, 3'd0, 32'h0000_8001);
    n_exp = w + 1;
    while (15 + (n_exp / DIV - w / DIV) != 20) n_exp++;
    n_seen = 0;
    for (int i = 0; i < 20 && n_seen == 0; i++) begin
      rd(CP0_CAUSE, 3'd0, v);
      if (v[30]) n_seen = edges;
      else cycle();
    end
    n_cmp++; if (n_seen !== n_exp) begin n_err++; $display("FAIL ti_edge: got %0d expected %0d", n_seen, n_exp); end
    n_cmp++; if (v[30] !== 1'b1 || v[15] !== 1'b1 || int_pending !== 1'b1) begin
      n_err++; $display("FAIL ti_pending: got cause=%h ip=%b expected TI,IP7,pending set", v, int_pending);
    end
    int_window = 1'b1; cur_pc = 32'h0000_2000;
    cycle(); idle();
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== V_EXC) begin
      n_err++; $display("FAIL int_redirect: got %b/%h expected 1/%h", redirect_valid, redirect_pc, V_EXC);
    end
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[6:2] !== EXC_INT) begin n_err++; $display("FAIL int_code: got %0d expected 0", v[6:2]); end
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v[1] !== 1'b1 || int_pending !== 1'b0) begin n_err++; $display("FAIL int_exl: got exl=%b ip=%b expected 1/0", v[1], int_pending); end
    rd(CP0_EPC, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_2000) begin n_err++; $display("FAIL int_epc: got %h expected 00002000", v); end
    cycle();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL redirect_one_cycle: got %b expected 0", redirect_valid); end
    wr(CP0_COMPARE, 3'd0, 32'h0010_0000);
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[30] !== 1'b0 || v[15] !== 1'b0) begin n_err++; $display("FAIL ti_clear: got %h expected TI,IP7 clear", v); end
  endtask

  task automatic test_sys_eret();
    logic [31:0] v;
    reset_dut();
    do_op(COP_OP_SYS, 32'h0000_1004, 1'b1);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== V_BEV) begin
      n_err++; $display("FAIL sys_redirect: got %b/%h expected 1/%h", redirect_valid, redirect_pc, V_BEV);
    end
    rd(CP0_EPC, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_1000) begin n_err++; $display("FAIL sys_epc: got %h expected 00001000", v); end
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[31] !== 1'b1 || v[6:2] !== EXC_SYS) begin n_err++; $display("FAIL sys_cause: got %h expected BD=1 code 8", v); end
    do_op(COP_OP_RET, 32'h0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_1000) begin
      n_err++; $display("FAIL eret_redirect: got %b/%h expected 1/00001000", redirect_valid, redirect_pc);
    end
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v[1] !== 1'b0) begin n_err++; $display("FAIL eret_exl: got %b expected 0", v[1]); end
    do_op(COP_OP_BRK, 32'h0000_3000, 1'b0);
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[31] !== 1'b0 || v[6:2] !== EXC_BP) begin n_err++; $display("FAIL brk_cause: got %h expected BD=0 code 9", v); end
  endtask

  task automatic test_priority_nested();
    logic [31:0] v, bva, bva2;
    reset_dut();
    wr(CP0_STATUS, 3'd0, 32'h0000_0401);
    hw_int = 6'b000001;
    cycle();
    n_cmp++; if (int_pending !== 1'b1) begin n_err++; $display("FAIL hw_pending: got %b expected 1", int_pending); end
    bva = $urandom;
    exc_valid = 1'b1; exc_code = EXC_ADEL; exc_badvaddr = bva; cur_pc = 32'h0000_4000;
    int_window = 1'b1; cop_op = COP_OP_MV; reg_wr = 1'b1; reg_num = CP0_EPC; in_data = 32'hDEAD_BEEF;
    cycle(); idle();
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== V_EXC) begin
      n_err++; $display("FAIL exc_redirect: got %b/%h expected 1/%h", redirect_valid, redirect_pc, V_EXC);
    end
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[6:2] !== EXC_ADEL) begin n_err++; $display("FAIL exc_over_int: got code %0d expected 4", v[6:2]); end
    rd(CP0_EPC, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_4000) begin n_err++; $display("FAIL mtc0_dropped: got %h expected 00004000", v); end
    rd(CP0_BADVADDR, 3'd0, v);
    n_cmp++; if (v !== bva) begin n_err++; $display("FAIL badvaddr: got %h expected %h", v, bva); end
    int_window = 1'b1; cycle(); idle();
    n_cmp++; if (redirect_valid !== 1'b0) begin n_err++; $display("FAIL int_blocked_exl: got %b expected 0", redirect_valid); end
    do_op(COP_OP_RET, 32'h0, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_4000) begin
      n_err++; $display("FAIL exc_eret: got %b/%h expected 1/00004000", redirect_valid, redirect_pc);
    end
    int_window = 1'b1; cur_pc = 32'h0000_4008; cycle(); idle();
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== V_EXC || v[6:2] !== EXC_INT) begin
      n_err++; $display("FAIL int_after_eret: got %b/%h code %0d expected 1/%h code 0", redirect_valid, redirect_pc, v[6:2], V_EXC);
    end
    bva2 = $urandom;
    exc_valid = 1'b1; exc_code = EXC_ADES; exc_badvaddr = bva2; cur_pc = 32'h0000_5000; in_delay_slot = 1'b1;
    cycle(); idle();
    rd(CP0_EPC, 3'd0, v);
    n_cmp++; if (v !== 32'h0000_4008) begin n_err++; $display("FAIL nested_epc: got %h expected 00004008", v); end
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[6:2] !== EXC_ADES || v[31] !== 1'b0) begin n_err++; $display("FAIL nested_cause: got %h expected code 5 BD 0", v); end
    rd(CP0_BADVADDR, 3'd0, v);
    n_cmp++; if (v !== bva2) begin n_err++; $display("FAIL nested_badvaddr: got %h expected %h", v, bva2); end
    hw_int = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] m_epc, m_errorepc, pc, exp, v;
    logic        m_exl, m_erl, m_bd, ds;
    logic [4:0]  m_code;
    int unsigned k;
    reset_dut();
    m_errorepc = $urandom;
    wr(CP0_ERROREPC, 3'd0, m_errorepc);
    wr(CP0_STATUS, 3'd0, 32'h0000_0004);
    m_epc = 0; m_exl = 0; m_erl = 1; m_bd = 0; m_code = 0;
    for (int i = 0; i < 32; i++) begin
      k  = $urandom_range(0, 2);
      pc = $urandom & 32'hFFFF_FFFC;
      ds = 1'($urandom);
      if (k == 2) begin
        if (m_erl) begin exp = m_errorepc; m_erl = 0; end
        else       begin exp = m_epc;      m_exl = 0; end
        do_op(COP_OP_RET, pc, ds);
      end else begin
        if (!m_exl) begin m_epc = ds ? pc - 32'd4 : pc; m_bd = ds; end
        m_exl = 1; m_code = (k == 0) ? 5'd8 : 5'd9; exp = V_EXC;
        do_op((k == 0) ? COP_OP_SYS : COP_OP_BRK, pc, ds);
      end
      n_cmp++; if (redirect_valid !== 1'b1 || redirect_pc !== exp) begin
        n_err++; $display("FAIL b2b_redirect[%0d]: got %b/%h expected 1/%h", i, redirect_valid, redirect_pc, exp);
      end
    end
    rd(CP0_EPC, 3'd0, v);
    n_cmp++; if (v !== m_epc) begin n_err++; $display("FAIL b2b_epc: got %h expected %h", v, m_epc); end
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v[31] !== m_bd || v[6:2] !== m_code) begin n_err++; $display("FAIL b2b_cause: got %h expected bd %b code %0d", v, m_bd, m_code); end
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v[2:1] !== {m_erl, m_exl}) begin n_err++; $display("FAIL b2b_status: got %b expected %b", v[2:1], {m_erl, m_exl}); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] v;
    do_op(COP_OP_SYS, 32'h0000_1234, 1'b0);
    n_cmp++; if (redirect_valid !== 1'b1) begin n_err++; $display("FAIL pre_reset_pulse: got %b expected 1", redirect_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'd0) begin
      n_err++; $display("FAIL reset_mid_redirect: got %b/%h expected 0/0", redirect_valid, redirect_pc);
    end
    rd(CP0_STATUS, 3'd0, v);
    n_cmp++; if (v !== 32'h0040_0000) begin n_err++; $display("FAIL reset_mid_status: got %h expected 00400000", v); end
    rd(CP0_EPC, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_mid_epc: got %h expected 0", v); end
    rd(CP0_CAUSE, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_mid_cause: got %h expected 0", v); end
    rd(CP0_COUNT, 3'd0, v);
    n_cmp++; if (v !== 32'd0) begin n_err++; $display("FAIL reset_mid_count: got %h expected 0", v); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
  endtask

  initial begin
    idle();
    test_reset();
    test_regs_random();
    test_timer();
    test_sys_eret();
    test_priority_nested();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
